// File: rtl/rf_arbiter_if.sv
// Single-beat register bus between the rf_arbiter (master) and a register-file slave.
interface reg_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  arvalid;
    logic                  aready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  bvalid;

    modport master (
        output waddr, wdata, wvalid, raddr, arvalid,
        input  wready, aready, rdata, rvalid, bvalid
    );

    modport slave (
        input  waddr, wdata, wvalid, raddr, arvalid,
        output wready, aready, rdata, rvalid, bvalid
    );
endinterface

// File: rtl/rf_arbiter.sv
// Round-robin arbiter serialising single-beat register accesses from NUM_REQ requesters.
// Optional watchdog enabled by defining RF_ARB_TIMEOUT_EN.
module rf_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    reg_if.master                            reg_o
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, RESP} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [GW-1:0]         winner, cand;
    logic                  found, accept;
    int                    idx;

`ifdef RF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx  = (int'(rr_ptr_q) + off) % NUM_REQ;
            cand = GW'(idx);
            if (req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Gated with rst_n so nothing is accepted while reset is held.
    assign accept = rst_n && (state_q == IDLE) && found;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef RF_ARB_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = winner;
                    write_d = req_write[winner];
                    addr_d  = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                    rdata_d = '0;
`ifdef RF_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q && reg_o.wready) begin
                    state_d = WAIT_B;
                end else if (!write_q && reg_o.aready && reg_o.rvalid) begin
                    rdata_d = reg_o.rdata;
                    state_d = RESP;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            WAIT_B: begin
                if (reg_o.bvalid) begin
                    state_d = RESP;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + GW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RF_ARB_TIMEOUT_EN
    // The watchdog restarts on every state change and only counts while waiting on the slave.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ISSUE) || (state_q == WAIT_B))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
`ifdef RF_ARB_TIMEOUT_EN
    assign rsp_err   = (state_q == RESP) && err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign grant_id  = accept ? winner : grant_q;
    assign busy      = (state_q != IDLE);

    assign reg_o.wvalid  = (state_q == ISSUE) && write_q;
    assign reg_o.arvalid = (state_q == ISSUE) && !write_q;
    assign reg_o.waddr   = addr_q;
    assign reg_o.raddr   = addr_q;
    assign reg_o.wdata   = wdata_q;
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed scoreboard bench for rf_arbiter with a zero-wait register-file slave model.
module tb_rf_arbiter;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [1:0]        grant_id;
    logic              busy;

    reg_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id), .busy(busy),
        .reg_o(bus)
    );

    // Slave model: reads answer in the same cycle, bvalid follows a write handshake by one cycle.
    logic [DW-1:0] mem [16] = '{32'h10000000, 32'hDEADBEEF, 32'h10000002, 32'h10000003,
                                32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                                32'h10000008, 32'h10000009, 32'h1000000A, 32'h1000000B,
                                32'h1000000C, 32'h1000000D, 32'h1000000E, 32'h1000000F};
    logic wready_en;
    logic bvalid_en;
    logic bvalid_r;

    assign bus.wready = wready_en;
    assign bus.aready = 1'b1;
    assign bus.rvalid = 1'b1;
    assign bus.rdata  = mem[bus.raddr];
    assign bus.bvalid = bvalid_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bvalid_r <= 1'b0;
        else        bvalid_r <= bus.wvalid && bus.wready && bvalid_en;
    end

    always @(posedge clk) begin
        if (bus.wvalid && bus.wready) mem[bus.waddr] <= bus.wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd);
        req_valid[idx]            = 1'b1;
        req_write[idx]            = wr;
        req_addr[idx*AW +: AW]    = addr;
        req_wdata[idx*DW +: DW]   = wd;
    endtask

    task automatic pushExp(input int idx, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.idx = idx; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic waitAccept(input int idx, input int maxc);
        int n = 0;
        bit seen = 0;
        while (!seen && n < maxc) begin
            @(negedge clk);
            if (req_ready[idx]) seen = 1;
            n++;
        end
        if (!seen) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitDrain(input int maxc);
        int n = 0;
        while (sb.size() > 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", sb.size(), 0);
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry.
    exp_t       mon_e;
    logic [3:0] mon_oh;
    always @(negedge clk) begin
        if (rst_n && rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", rsp_valid, 0);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 4'b0001 << mon_e.idx;
                checkOutput("rsp_valid_id", rsp_valid, mon_oh);
                checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
                checkOutput("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    int order[5] = '{0, 1, 2, 3, 0};
    int cyc, prev, ng;
    bit seen;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        wready_en = 1'b1; bvalid_en = 1'b1;
        #12;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wvalid", bus.wvalid, 0);
        checkOutput("rst_arvalid", bus.arvalid, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single read by requester 2
        @(posedge clk); #1;
        applyStimulus(2, 1'b0, 4'd1, 32'h0);
        pushExp(2, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        checkOutput("rd_ready_c0", req_ready, 4'b0100);
        checkOutput("rd_grant_id", grant_id, 2);
        @(posedge clk); #1; req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("rd_arvalid_c1", bus.arvalid, 1);
        checkOutput("rd_raddr_c1", bus.raddr, 1);
        checkOutput("rd_wvalid_c1", bus.wvalid, 0);
        @(negedge clk);
        checkOutput("rd_rsp_c2", rsp_valid, 4'b0100);
        waitDrain(10);

        // Write then read back by requester 0
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 4'd3, 32'h12345678);
        pushExp(0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("wr_ready_c0", req_ready, 4'b0001);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("wr_wvalid_c1", bus.wvalid, 1);
        checkOutput("wr_waddr_c1", bus.waddr, 3);
        checkOutput("wr_wdata_c1", bus.wdata, 32'h12345678);
        checkOutput("wr_arvalid_c1", bus.arvalid, 0);
        @(negedge clk);
        checkOutput("wr_wvalid_c2", bus.wvalid, 0);
        checkOutput("wr_rsp_c2", rsp_valid, 0);
        checkOutput("wr_busy_c2", busy, 1);
        @(negedge clk);
        checkOutput("wr_rsp_c3", rsp_valid, 4'b0001);
        waitDrain(10);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 4'd3, 32'h0);
        pushExp(0, 32'h12345678, 1'b0);
        waitAccept(0, 10);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        waitDrain(10);

        // Round robin from reset with all requesters reading continuously
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, AW'(4 + i), 32'h0);
        cyc = 0; prev = 0; ng = 0;
        while (ng < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_ready !== '0) begin
                checkOutput("rr_grant", req_ready, 4'b0001 << order[ng]);
                if (ng > 0) checkOutput("rr_gap", cyc - prev, 3);
                pushExp(order[ng], 32'h10000004 + order[ng], 1'b0);
                prev = cyc;
                ng++;
                if (ng == 5) begin
                    @(posedge clk); #1; req_valid = '0;
                end
            end
        end
        checkOutput("rr_grants_seen", ng, 5);
        waitDrain(20);

        // Back-pressure: write held off for five cycles while requester 2 also waits
        @(posedge clk); #1;
        wready_en = 1'b0;
        applyStimulus(1, 1'b1, 4'd9, 32'hA5A5A5A5);
        applyStimulus(2, 1'b0, 4'd9, 32'h0);
        pushExp(1, 32'h0, 1'b0);
        pushExp(2, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        checkOutput("bp_ready_c0", req_ready, 4'b0010);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_wvalid", bus.wvalid, 1);
            checkOutput("bp_waddr", bus.waddr, 9);
            checkOutput("bp_wdata", bus.wdata, 32'hA5A5A5A5);
            checkOutput("bp_no_grant", req_ready, 0);
        end
        @(posedge clk); #1; wready_en = 1'b1;
        waitAccept(2, 20);
        @(posedge clk); #1; req_valid[2] = 1'b0;
        waitDrain(20);

        // Reset while waiting for bvalid drops the transaction
        @(posedge clk); #1;
        bvalid_en = 1'b0;
        applyStimulus(3, 1'b1, 4'd2, 32'hCAFEF00D);
        applyStimulus(0, 1'b0, 4'd3, 32'h0);
        waitAccept(3, 10);
        checkOutput("mid_rst_grant", req_ready, 4'b1000);
        @(posedge clk); #1; req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_rst_waitb_busy", busy, 1);
        checkOutput("mid_rst_waitb_wvalid", bus.wvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        applyStimulus(3, 1'b0, 4'd5, 32'h0);
        #1;
        checkOutput("mr_req_ready", req_ready, 0);
        checkOutput("mr_rsp_valid", rsp_valid, 0);
        checkOutput("mr_rsp_rdata", rsp_rdata, 0);
        checkOutput("mr_rsp_err", rsp_err, 0);
        checkOutput("mr_grant_id", grant_id, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_wvalid", bus.wvalid, 0);
        checkOutput("mr_arvalid", bus.arvalid, 0);
        checkOutput("mr_waddr", bus.waddr, 0);
        checkOutput("mr_raddr", bus.raddr, 0);
        checkOutput("mr_wdata", bus.wdata, 0);
        bvalid_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mr_first_winner", req_ready, 4'b0001);
        pushExp(0, 32'h12345678, 1'b0);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        pushExp(3, 32'h10000005, 1'b0);
        waitAccept(3, 10);
        @(posedge clk); #1; req_valid[3] = 1'b0;
        waitDrain(20);

        // Slave never answers a write with bvalid
        @(posedge clk); #1;
        bvalid_en = 1'b0;
        applyStimulus(1, 1'b1, 4'd10, 32'h55AA55AA);
`ifdef RF_ARB_TIMEOUT_EN
        pushExp(1, 32'h0, 1'b1);
`endif
        waitAccept(1, 10);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== '0) seen = 1;
        end
`ifdef RF_ARB_TIMEOUT_EN
        checkOutput("to_latency", cyc, 18);
        checkOutput("to_rsp_seen", seen, 1);
        waitDrain(5);
`else
        checkOutput("no_to_rsp", seen, 0);
        checkOutput("no_to_busy", busy, 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
`endif
        bvalid_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
